// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
//
// Shared definitions for the data-cache flush/fill controller:
//   - default memory-block geometry (word width, word-address width, line size)
//   - flush FSM state encoding
//   - statistics counter width and its saturating increment helper
//
// Optional build macro used by the importing files: DCACHE_FLUSH_STATS_EN
// -----------------------------------------------------------------------------
package dcache_pkg;

   localparam int DCACHE_DATABITS = 32;
   localparam int DCACHE_ADDRBITS = 5;
   localparam int DCACHE_LINEBITS = 3;
   localparam int DCACHE_STAT_W   = 16;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WB_RD    = 3'd1,
      ST_WB_CAP   = 3'd2,
      ST_WB_REQ   = 3'd3,
      ST_FILL_REQ = 3'd4,
      ST_FILL_WR  = 3'd5,
      ST_DONE     = 3'd6
   } flush_state_e;

   // Saturating increment: sticks at all ones instead of wrapping.
   function automatic logic [DCACHE_STAT_W-1:0] stat_sat_inc(
      input logic [DCACHE_STAT_W-1:0] v
   );
      return (&v) ? v : v + DCACHE_STAT_W'(1);
   endfunction

endpackage

// File: rtl/dcache_flush_cnt.sv
// -----------------------------------------------------------------------------
// dcache_flush_cnt
//
// Word counter within a cache line for the flush/fill controller.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   clr      in   synchronous clear to word 0 (wins over inc)
//   inc      in   advance to the next word
//   cnt      out  current word index within the line
//   last     out  1 when cnt addresses the final word of the line
// -----------------------------------------------------------------------------
module dcache_flush_cnt
   import dcache_pkg::*;
#(
   parameter int LINEBITS = DCACHE_LINEBITS
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                clr,
   input  logic                inc,
   output logic [LINEBITS-1:0] cnt,
   output logic                last
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + LINEBITS'(1);
      end
   end

   assign last = &cnt;

endmodule

// File: rtl/dcache_flush_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_flush_ctrl
//
// Flush/fill controller for the data-cache memory block. On a start pulse it
// writes one cache line back to main memory (only when the line is dirty) and
// then refills the same line from main memory, one word per bus beat. While
// busy it owns the memory block through the flush port.
//
// Optional feature (build macro DCACHE_FLUSH_STATS_EN): adds saturating
// request counters stat_wb (dirty requests) and stat_fill (all requests),
// both bumped when a request completes.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 one-cycle request pulse, taken only while idle
//   line_idx              cache line to process
//   dirty                 1 = write the line back before refilling it
//   wb_base, fill_base    main-memory word address of line word 0
//   busy                  high from acceptance until the done cycle
//   done                  one-cycle completion pulse
//   flush_mode            memory block flush-port select (equals busy)
//   flush_addr            memory block word address {line, word}
//   flush_in              fill data to the memory block
//   flush_we              memory block write strobe
//   flush_byteenable      all lanes while flush_we is high
//   flush_out             memory block read data, one cycle after flush_addr
//   mem_req/mem_we        bus request / write beat; request held until ack
//   mem_addr, mem_wdata   beat address (base + word) and writeback data
//   mem_ack, mem_rdata    beat complete; read data valid with the ack
//   stat_wb, stat_fill    (DCACHE_FLUSH_STATS_EN only) request counters
// -----------------------------------------------------------------------------
module dcache_flush_ctrl
   import dcache_pkg::*;
#(
   parameter int DATABITS    = DCACHE_DATABITS,
   parameter int ADDRBITS    = DCACHE_ADDRBITS,
   parameter int BANKNUM     = 4,
   parameter int LINEBITS    = DCACHE_LINEBITS,
   parameter int MEMADDRBITS = 32
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         start,
   input  logic [ADDRBITS-LINEBITS-1:0] line_idx,
   input  logic                         dirty,
   input  logic [MEMADDRBITS-1:0]       wb_base,
   input  logic [MEMADDRBITS-1:0]       fill_base,
   output logic                         busy,
   output logic                         done,
   output logic                         flush_mode,
   output logic [ADDRBITS-1:0]          flush_addr,
   output logic [DATABITS-1:0]          flush_in,
   output logic                         flush_we,
   output logic [BANKNUM-1:0]           flush_byteenable,
   input  logic [DATABITS-1:0]          flush_out,
   output logic                         mem_req,
   output logic                         mem_we,
   output logic [MEMADDRBITS-1:0]       mem_addr,
   output logic [DATABITS-1:0]          mem_wdata,
   input  logic                         mem_ack,
   input  logic [DATABITS-1:0]          mem_rdata
`ifdef DCACHE_FLUSH_STATS_EN
   ,
   output logic [DCACHE_STAT_W-1:0]     stat_wb,
   output logic [DCACHE_STAT_W-1:0]     stat_fill
`endif
);

   localparam int LW = ADDRBITS - LINEBITS;

   flush_state_e            state_q;
   flush_state_e            state_d;

   logic [LW-1:0]           line_q;
   logic                    dirty_q;
   logic [MEMADDRBITS-1:0]  wb_base_q;
   logic [MEMADDRBITS-1:0]  fill_base_q;

   logic [LINEBITS-1:0]     cnt;
   logic                    cnt_last;
   logic                    cnt_clr;
   logic                    cnt_inc;
   logic [MEMADDRBITS-1:0]  cnt_ext;

   logic                    accept;

   assign accept  = (state_q == ST_IDLE) && start;
   assign cnt_ext = {{(MEMADDRBITS-LINEBITS){1'b0}}, cnt};

   // ---------------------------------------------------------------------------
   // Word counter
   // ---------------------------------------------------------------------------
   dcache_flush_cnt #(
      .LINEBITS (LINEBITS)
   ) u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (cnt_clr),
      .inc     (cnt_inc),
      .cnt     (cnt),
      .last    (cnt_last)
   );

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = dirty ? ST_WB_RD : ST_FILL_REQ;
            end
         end
         ST_WB_RD:  state_d = ST_WB_CAP;
         ST_WB_CAP: state_d = ST_WB_REQ;
         ST_WB_REQ: begin
            if (mem_ack) begin
               state_d = cnt_last ? ST_FILL_REQ : ST_WB_RD;
            end
         end
         ST_FILL_REQ: begin
            if (mem_ack) begin
               state_d = ST_FILL_WR;
            end
         end
         ST_FILL_WR: state_d = cnt_last ? ST_DONE : ST_FILL_REQ;
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs and counter control
   // All bus and flush strobes decode straight from the state register, so an
   // asynchronous reset drops them immediately without waiting for a clock.
   // ---------------------------------------------------------------------------
   always_comb begin
      busy     = (state_q != ST_IDLE);
      done     = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      mem_addr = '0;
      flush_we = 1'b0;
      cnt_clr  = 1'b0;
      cnt_inc  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_clr = start;
         end
         ST_WB_REQ: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = wb_base_q + cnt_ext;
            if (mem_ack) begin
               cnt_clr = cnt_last;
               cnt_inc = !cnt_last;
            end
         end
         ST_FILL_REQ: begin
            mem_req  = 1'b1;
            mem_addr = fill_base_q + cnt_ext;
         end
         ST_FILL_WR: begin
            flush_we = 1'b1;
            cnt_clr  = cnt_last;
            cnt_inc  = !cnt_last;
         end
         ST_DONE: begin
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   assign flush_mode       = busy;
   assign flush_addr       = {line_q, cnt};
   assign flush_byteenable = {BANKNUM{flush_we}};

   // ---------------------------------------------------------------------------
   // Request latch and data capture
   // mem_wdata is loaded only in WB_CAP, so it cannot change while a write
   // beat is waiting for its ack.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         line_q      <= '0;
         dirty_q     <= 1'b0;
         wb_base_q   <= '0;
         fill_base_q <= '0;
         mem_wdata   <= '0;
         flush_in    <= '0;
      end else begin
         if (accept) begin
            line_q      <= line_idx;
            dirty_q     <= dirty;
            wb_base_q   <= wb_base;
            fill_base_q <= fill_base;
         end
         if (state_q == ST_WB_CAP) begin
            mem_wdata <= flush_out;
         end
         if ((state_q == ST_FILL_REQ) && mem_ack) begin
            flush_in <= mem_rdata;
         end
      end
   end

`ifdef DCACHE_FLUSH_STATS_EN
   // ---------------------------------------------------------------------------
   // Completion statistics
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_wb   <= '0;
         stat_fill <= '0;
      end else if (state_q == ST_DONE) begin
         stat_fill <= stat_sat_inc(stat_fill);
         if (dirty_q) begin
            stat_wb <= stat_sat_inc(stat_wb);
         end
      end
   end
`endif

endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dcache_flush_ctrl
//
// Directed bench for dcache_flush_ctrl: a table of flush/fill requests with
// hand-computed latencies, plus hand-written sequences for a second start
// while busy and a reset in the middle of a fill. A behavioural memory block
// and a single-beat bus responder with programmable ack delay surround the DUT.
// -----------------------------------------------------------------------------
module tb_dcache_flush_ctrl;

   typedef struct {
      logic [1:0]  line;
      logic        dirty;
      logic [31:0] wb_base;
      logic [31:0] fill_base;
      logic [31:0] rdata_base;
      int          delay;
      int          exp_cycles;
   } vec_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } beat_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [1:0]  line_idx;
   logic        dirty;
   logic [31:0] wb_base;
   logic [31:0] fill_base;
   logic        busy;
   logic        done;
   logic        flush_mode;
   logic [4:0]  flush_addr;
   logic [31:0] flush_in;
   logic        flush_we;
   logic [3:0]  flush_byteenable;
   logic [31:0] flush_out;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   dcache_flush_ctrl dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .start            (start),
      .line_idx         (line_idx),
      .dirty            (dirty),
      .wb_base          (wb_base),
      .fill_base        (fill_base),
      .busy             (busy),
      .done             (done),
      .flush_mode       (flush_mode),
      .flush_addr       (flush_addr),
      .flush_in         (flush_in),
      .flush_we         (flush_we),
      .flush_byteenable (flush_byteenable),
      .flush_out        (flush_out),
      .mem_req          (mem_req),
      .mem_we           (mem_we),
      .mem_addr         (mem_addr),
      .mem_wdata        (mem_wdata),
      .mem_ack          (mem_ack),
      .mem_rdata        (mem_rdata)
   );

   // Bus responder: ack after ack_delay waiting cycles, read data derived
   // from the offset into the current fill line.
   int          ack_delay;
   int          wait_cnt;
   logic [31:0] rdata_base;
   logic [31:0] cur_fill_base;

   assign mem_ack   = mem_req && (wait_cnt >= ack_delay);
   assign mem_rdata = rdata_base + (mem_addr - cur_fill_base);

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n)                wait_cnt <= 0;
      else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
      else                         wait_cnt <= 0;
   end

   // Memory block model: synchronous read, byte-lane write.
   function automatic logic [31:0] pre_val(input int i);
      if ((i >> 3) == 1) return 32'h1111_0000 + 32'(i % 8);
      return 32'hDEAD_0000 + 32'(i);
   endfunction

   logic [31:0] mem [32];
   logic        preload_go;

   always @(posedge clk) begin
      if (preload_go) begin
         for (int i = 0; i < 32; i++) mem[i] <= pre_val(i);
      end else if (flush_we) begin
         for (int b = 0; b < 4; b++)
            if (flush_byteenable[b]) mem[flush_addr][8*b +: 8] <= flush_in[8*b +: 8];
      end
      flush_out <= mem[flush_addr];
   end

   // Scoreboard state, all owned by the stimulus process.
   int          n_checks;
   int          n_fail;
   int          n_flush_we;
   int          n_done;
   int          stab_err;
   int          be_err;
   beat_t       beats[$];
   logic        pend;
   logic        h_we;
   logic [31:0] h_addr;
   logic [31:0] h_wdata;
   vec_t        vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic sample();
      if (pend && mem_req &&
          (mem_addr !== h_addr || mem_we !== h_we || mem_wdata !== h_wdata))
         stab_err++;
      pend    = mem_req && !mem_ack;
      h_we    = mem_we;
      h_addr  = mem_addr;
      h_wdata = mem_wdata;
      if (mem_req && mem_ack) beats.push_back('{mem_we, mem_addr, mem_wdata});
      if (flush_we) n_flush_we++;
      if (flush_byteenable !== (flush_we ? 4'hF : 4'h0)) be_err++;
      if (done) n_done++;
   endtask

   task automatic tick();
      @(negedge clk);
      sample();
   endtask

   task automatic clear_stats();
      n_flush_we = 0;
      n_done     = 0;
      stab_err   = 0;
      be_err     = 0;
      pend       = 1'b0;
      beats.delete();
   endtask

   task automatic preload();
      preload_go = 1'b1;
      tick();
      preload_go = 1'b0;
   endtask

   // Runs one request and checks latency, bus beats, line contents and strobes.
   // extra_at > 0 fires an ignored second start at that cycle of the request.
   task automatic run_vec(input vec_t v, input int extra_at, input string tag);
      int cyc;
      int nw;
      ack_delay     = v.delay;
      rdata_base    = v.rdata_base;
      cur_fill_base = v.fill_base;
      preload();
      clear_stats();
      line_idx  = v.line;
      dirty     = v.dirty;
      wb_base   = v.wb_base;
      fill_base = v.fill_base;
      start     = 1'b1;
      cyc       = 1;
      while (!done && cyc < 1000) begin
         tick();
         cyc++;
         if (cyc == 2) start = 1'b0;
         if (cyc == extra_at) begin
            start     = 1'b1;
            line_idx  = 2'd3;
            dirty     = 1'b0;
            fill_base = 32'h999;
         end else if (cyc == extra_at + 1) begin
            start = 1'b0;
         end
      end
      check({tag, "_latency"}, 32'(cyc), 32'(v.exp_cycles));
      tick();
      check({tag, "_busy_after_done"}, busy, 1'b0);
      repeat (20) tick();
      nw = v.dirty ? 8 : 0;
      check({tag, "_beats"}, 32'(beats.size()), 32'(nw + 8));
      for (int i = 0; i < beats.size(); i++) begin
         if (i < nw + 8) begin
            check($sformatf("%s_beat%0d_we", tag, i), beats[i].we, (i < nw));
            if (i < nw) begin
               check($sformatf("%s_beat%0d_addr", tag, i), beats[i].addr, v.wb_base + 32'(i));
               check($sformatf("%s_beat%0d_wdata", tag, i), beats[i].data,
                     pre_val(int'(v.line) * 8 + i));
            end else begin
               check($sformatf("%s_beat%0d_addr", tag, i), beats[i].addr,
                     v.fill_base + 32'(i - nw));
            end
         end
      end
      for (int n = 0; n < 8; n++)
         check($sformatf("%s_line_word%0d", tag, n), mem[int'(v.line) * 8 + n],
               v.rdata_base + 32'(n));
      check({tag, "_flush_we_count"}, 32'(n_flush_we), 32'd8);
      check({tag, "_done_count"}, 32'(n_done), 32'd1);
      check({tag, "_bus_stable"}, 32'(stab_err), 32'd0);
      check({tag, "_byteenable"}, 32'(be_err), 32'd0);
   endtask

   initial begin
      int guard;
      n_checks      = 0;
      n_fail        = 0;
      reset_n       = 1'b0;
      start         = 1'b0;
      line_idx      = '0;
      dirty         = 1'b0;
      wb_base       = '0;
      fill_base     = '0;
      ack_delay     = 0;
      rdata_base    = '0;
      cur_fill_base = '0;
      preload_go    = 1'b0;
      clear_stats();

      //          line  dirty wb_base        fill_base      rdata_base     dly cycles
      vecs[0] = '{2'd2, 1'b0, 32'h0000_0000, 32'h0000_0100, 32'h0000_00A0, 0, 18};
      vecs[1] = '{2'd1, 1'b1, 32'h0000_0200, 32'h0000_0300, 32'h5500_0000, 0, 42};
      vecs[2] = '{2'd1, 1'b1, 32'h0000_0200, 32'h0000_0300, 32'h5500_0000, 5, 122};
      vecs[3] = '{2'd3, 1'b0, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_00C0, 0, 18};
      vecs[4] = '{2'd0, 1'b1, 32'hFFFF_FFFE, 32'h0000_0040, 32'h0000_0077, 1, 58};

      repeat (3) tick();
      check("rst_busy",       busy,             1'b0);
      check("rst_done",       done,             1'b0);
      check("rst_flush_mode", flush_mode,       1'b0);
      check("rst_flush_we",   flush_we,         1'b0);
      check("rst_byteenable", flush_byteenable, 4'h0);
      check("rst_flush_addr", flush_addr,       5'h0);
      check("rst_flush_in",   flush_in,         32'h0);
      check("rst_mem_req",    mem_req,          1'b0);
      check("rst_mem_we",     mem_we,           1'b0);
      check("rst_mem_addr",   mem_addr,         32'h0);
      check("rst_mem_wdata",  mem_wdata,        32'h0);
      reset_n = 1'b1;
      repeat (2) tick();

      for (int k = 0; k < 5; k++) run_vec(vecs[k], 0, $sformatf("vec%0d", k));

      // Second start in the middle of the writeback must be ignored.
      run_vec(vecs[1], 10, "start_busy");

      // Reset while a stalled fill beat is outstanding.
      ack_delay     = 5;
      rdata_base    = 32'h0000_00A0;
      cur_fill_base = 32'h0000_0100;
      preload();
      clear_stats();
      line_idx  = 2'd2;
      dirty     = 1'b0;
      fill_base = 32'h0000_0100;
      start     = 1'b1;
      tick();
      start = 1'b0;
      guard = 0;
      while (!(mem_req && !mem_we && wait_cnt >= 2) && guard < 100) begin
         tick();
         guard++;
      end
      check("rstmid_in_fill_req", (mem_req && !mem_we), 1'b1);
      #1 reset_n = 1'b0;
      #1;
      check("rstmid_busy",       busy,       1'b0);
      check("rstmid_flush_mode", flush_mode, 1'b0);
      check("rstmid_mem_req",    mem_req,    1'b0);
      check("rstmid_flush_we",   flush_we,   1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) tick();
      run_vec(vecs[0], 0, "after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dcache_flush_ctrl.md
Name: dcache_flush_ctrl

Overview:
- Flush/fill controller that drives the flush port of the data-cache memory block: flush_mode, flush_addr, flush_in, flush_we, flush_byteenable.
- On a request it writes back one cache line (if dirty) from the memory block to main memory, then refills that line from main memory.
- Sits between the dcache tag/control logic and the single-beat main-memory bus; owns the memory block exclusively while busy.

Parameters:
- DATABITS, 32, word width; must match the memory block.
- ADDRBITS, 5, memory block word-address width.
- BANKNUM, 4, byte lanes (flush_byteenable width).
- LINEBITS, 3, log2 words per line (8 words); the line index is ADDRBITS-LINEBITS bits.
- MEMADDRBITS, 32, main-memory word-address width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request pulse; accepted only when busy=0.
- line_idx  in  ADDRBITS-LINEBITS  cache line to process.
- dirty  in  1  1 = write back before fill.
- wb_base  in  MEMADDRBITS  main-memory word address of line word 0, writeback.
- fill_base  in  MEMADDRBITS  main-memory word address of line word 0, fill.
- busy  out  1  high from the accepting cycle until done.
- done  out  1  one-cycle pulse at completion.
- flush_mode  out  1  equals busy.
- flush_addr  out  ADDRBITS  {line_idx, word counter}.
- flush_in  out  DATABITS  fill data to the memory block.
- flush_we  out  1  memory block write strobe.
- flush_byteenable  out  BANKNUM  all ones while flush_we=1, else 0.
- flush_out  in  DATABITS  memory block data_out; synchronous, valid 1 cycle after flush_addr.
- mem_req  out  1  bus request; held until mem_ack.
- mem_we  out  1  1 = write beat, 0 = read beat.
- mem_addr  out  MEMADDRBITS  base + word counter (modulo 2^MEMADDRBITS).
- mem_wdata  out  DATABITS  writeback data.
- mem_ack  in  1  beat complete; read data valid in the same cycle.
- mem_rdata  in  DATABITS  read data.

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, word counter 0, latched request fields 0.
- IDLE: when start=1, latch line_idx, dirty, wb_base and fill_base; set busy. Go to WB_RD if dirty=1, else FILL_REQ. start while busy=1 is ignored.
- WB_RD (1 cycle): flush_addr = {line, cnt}. Go to WB_CAP.
- WB_CAP (1 cycle): register flush_out into mem_wdata. Go to WB_REQ.
- WB_REQ: mem_req=1, mem_we=1, mem_addr = wb_base+cnt; mem_wdata and mem_addr stay stable until mem_ack. On mem_ack: if cnt is the last word, clear cnt and go to FILL_REQ; else increment cnt and go to WB_RD.
- FILL_REQ: mem_req=1, mem_we=0, mem_addr = fill_base+cnt. On mem_ack: capture mem_rdata into flush_in and go to FILL_WR.
- FILL_WR (1 cycle): flush_we=1, flush_byteenable all ones, flush_addr = {line, cnt}. If last word go to DONE; else increment cnt and go to FILL_REQ.
- DONE (1 cycle): done=1, busy drops in the next cycle, go to IDLE.
- Bus protocol: mem_req may only drop after mem_ack. mem_ack outside WB_REQ/FILL_REQ is ignored. mem_ack in the first cycle of the request is legal.
- Latency with ack-on-first-cycle: clean line = 1+2*8+1 cycles; dirty line adds 3*8 cycles.
- Counter: LINEBITS wide; wraps to 0 at phase end.
- Reset mid-operation aborts immediately: mem_req, flush_we and flush_mode go low asynchronously, and the line content is undefined.

Optional Feature:
- DCACHE_FLUSH_STATS_EN defined:
  - adds outputs stat_wb[15:0] and stat_fill[15:0], incremented at DONE for dirty and for all requests respectively;
  - both saturate at 16'hFFFF and clear on reset.
- Not defined: the ports are absent and there is no extra logic.

Decomposition:
- Shared package dcache_pkg: FSM state encoding (IDLE, WB_RD, WB_CAP, WB_REQ, FILL_REQ, FILL_WR, DONE), default DATABITS/ADDRBITS/LINEBITS constants, and the stats counter width.
- Sub-module dcache_flush_cnt, natural as a separate block: word counter with clear, increment and last-word flag.

Test Plan:
- Clean fill: start, line_idx=2, dirty=0, fill_base=0x100, ack on first cycle, rdata=0xA0+n.
  - Memory block words 16..23 hold 0xA0..0xA7, with no write beats.
  - done 18 cycles after start.
- Dirty line: memory block line 1 preloaded with 0x11110000+n, wb_base=0x200, fill_base=0x300.
  - 8 write beats at 0x200..0x207 carrying the preload, then 8 reads at 0x300..0x307.
  - flush_we fires exactly 8 times.
- Bus stall: mem_ack delayed 5 cycles on every beat.
  - mem_addr, mem_we and mem_wdata stay stable while mem_req is high; results match the unstalled run.
- start while busy: a second start mid-writeback is ignored; exactly one done pulse is produced.
- Address wrap: fill_base=0xFFFFFFFC reads 0xFFFFFFFC..0xFFFFFFFF, then 0x0..0x3.
- Reset mid-fill: reset_n low in FILL_REQ clears busy, flush_mode and mem_req at once. A new request afterwards completes normally.
